// File: rtl/adpll_dco_tdc_emu.sv
// adpll_dco_tdc_emu
// Digital stand-in for the DCO + TDC analog front-end of an ADPLL.
// The capacitor-bank codes are decoded into unit counts (stage 1). The unit
// counts are mapped linearly onto a Q13.14 DCO/ref ratio (stage 2). The ratio
// is integrated once per reference cycle into a 27-bit phase accumulator
// (stage 3). The accumulator is presented as a ripple count plus a
// thermometer-coded fraction, gated by a TDC power-up state machine.
//
// Handshake: there is no valid/ready pair. All inputs are sampled on every
// posedge where en = 1, and every register holds while en = 0. tdc_valid
// qualifies tdc_ripple_count/tdc_phase: when it is 1 they carry live phase,
// and when it is 0 they are forced to zero.
module adpll_dco_tdc_emu #(
    parameter logic [26:0] N0_Q   = 27'd1228800,
    parameter int          KL     = 8192,
    parameter int          KM     = 256,
    parameter int          KS     = 16,
    parameter int          WARMUP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        dco_pd,
    input  logic        tdc_pd,
    input  logic        tdc_pd_inj,
    input  logic [4:0]  dco_c_l_rall,
    input  logic [4:0]  dco_c_l_row,
    input  logic [4:0]  dco_c_l_col,
    input  logic [15:0] dco_c_m_rall,
    input  logic [15:0] dco_c_m_row,
    input  logic [15:0] dco_c_m_col,
    input  logic [15:0] dco_c_s_rall,
    input  logic [15:0] dco_c_s_row,
    input  logic [15:0] dco_c_s_col,
    output logic [6:0]  tdc_ripple_count,
    output logic [15:0] tdc_phase,
    output logic [26:0] dco_ratio,
    output logic        code_err,
    output logic        tdc_valid
);

    localparam int          CW        = $clog2(WARMUP + 1);
    localparam logic [CW-1:0] WARM_LOAD = CW'(WARMUP);

    typedef enum logic [1:0] {
        TDC_OFF  = 2'd0,
        TDC_WARM = 2'd1,
        TDC_LIVE = 2'd2
    } tdc_state_t;

    // ------------------------------------------------------------------
    // Bank decode helpers. The large bank is zero-extended to 16 bits, so
    // one set of helpers serves all three banks.
    // ------------------------------------------------------------------
    function automatic logic [4:0] popcnt16(input logic [15:0] x);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, x[i]};
        end
        return c;
    endfunction

    // Contiguous ones from the LSB: x & (x + 1) clears to zero.
    function automatic logic is_therm(input logic [15:0] x);
        logic [16:0] xe;
        xe = {1'b0, x};
        return ((xe & (xe + 17'd1)) == 17'd0);
    endfunction

    // The row must select the partially filled row that sits just above the
    // full rows. A full bank leaves no such row, so col != 0 is then malformed.
    function automatic logic bank_bad(input logic [15:0] rall,
                                      input logic [15:0] row,
                                      input logic [15:0] col);
        logic [16:0] want;
        logic        bad;
        want = 17'd1 << popcnt16(rall);
        bad  = !is_therm(rall) || !is_therm(col);
        if (col == 16'd0) begin
            bad = bad || (row != 16'd0);
        end else begin
            bad = bad || ({1'b0, row} != want);
        end
        return bad;
    endfunction

    // units = W*popcount(rall) + popcount(col), where W is 16 (wide) or 5.
    function automatic logic [8:0] bank_units(input logic [15:0] rall,
                                              input logic [15:0] col,
                                              input logic        wide);
        logic [4:0] p;
        logic [8:0] u;
        p = popcnt16(rall);
        if (wide) begin
            u = {p, 4'd0};
        end else begin
            u = {2'd0, p, 2'd0} + {4'd0, p};
        end
        return u + {4'd0, popcnt16(col)};
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: registered unit counts and code error flag
    // ------------------------------------------------------------------
    logic [15:0] l_rall_x, l_row_x, l_col_x;
    logic [8:0]  nl_d, nm_d, ns_d;
    logic        err_d;
    logic [8:0]  nl_q, nm_q, ns_q;

    // Decode all three banks combinationally ahead of the stage-1 register.
    always_comb begin
        l_rall_x = {11'd0, dco_c_l_rall};
        l_row_x  = {11'd0, dco_c_l_row};
        l_col_x  = {11'd0, dco_c_l_col};
        nl_d     = bank_units(l_rall_x, l_col_x, 1'b0);
        nm_d     = bank_units(dco_c_m_rall, dco_c_m_col, 1'b1);
        ns_d     = bank_units(dco_c_s_rall, dco_c_s_col, 1'b1);
        err_d    = bank_bad(l_rall_x, l_row_x, l_col_x)
                 | bank_bad(dco_c_m_rall, dco_c_m_row, dco_c_m_col)
                 | bank_bad(dco_c_s_rall, dco_c_s_row, dco_c_s_col);
    end

    // Register the decoded unit counts and the malformed-code flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nl_q     <= '0;
            nm_q     <= '0;
            ns_q     <= '0;
            code_err <= 1'b0;
        end else if (en) begin
            nl_q     <= nl_d;
            nm_q     <= nm_d;
            ns_q     <= ns_d;
            code_err <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: linear frequency model, saturated to the 27-bit ratio range
    // ------------------------------------------------------------------
    logic signed [31:0] ratio_raw;
    logic [26:0]        ratio_sat;

    // Offsets are taken from the centre codes (13 large, 128 medium, 128 small).
    always_comb begin
        ratio_raw = $signed({5'd0, N0_Q})
                  - KL * ($signed({23'd0, nl_q}) - 32'sd13)
                  - KM * ($signed({23'd0, nm_q}) - 32'sd128)
                  - KS * ($signed({23'd0, ns_q}) - 32'sd128);
        if (ratio_raw < 32'sd0) begin
            ratio_sat = '0;
        end else if (ratio_raw > 32'sd134217727) begin
            ratio_sat = '1;
        end else begin
            ratio_sat = ratio_raw[26:0];
        end
    end

    // Ratio register. A powered-down DCO does not oscillate, so the ratio is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dco_ratio <= '0;
        end else if (en) begin
            dco_ratio <= dco_pd ? 27'd0 : ratio_sat;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: phase accumulator, wraps mod 2^27
    // ------------------------------------------------------------------
    logic [26:0] acc_q;

    // Integrate the ratio once per reference cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + dco_ratio;
        end
    end

    // ------------------------------------------------------------------
    // TDC power state machine: OFF -> WARM -> LIVE
    // ------------------------------------------------------------------
    tdc_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pd_any;

    // State and warm-up counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TDC_OFF;
            cnt_q   <= WARM_LOAD;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. WARM counts the warm-up down and hands over to LIVE
    // on the cycle where the count reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pd_any  = tdc_pd | tdc_pd_inj;
        case (state_q)
            TDC_OFF: begin
                cnt_d = WARM_LOAD;
                if (!pd_any) begin
                    state_d = TDC_WARM;
                end
            end
            TDC_WARM: begin
                if (pd_any) begin
                    state_d = TDC_OFF;
                    cnt_d   = WARM_LOAD;
                end else if (cnt_q <= CW'(1)) begin
                    state_d = TDC_LIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TDC_LIVE: begin
                if (pd_any) begin
                    state_d = TDC_OFF;
                    cnt_d   = WARM_LOAD;
                end
            end
            default: begin
                state_d = TDC_OFF;
                cnt_d   = WARM_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // TDC output registers
    // ------------------------------------------------------------------
    logic [15:0] phase_d;

    // Thermometer fraction: k ones from the LSB, where k = acc[13:10].
    always_comb begin
        phase_d = (16'd1 << acc_q[13:10]) - 16'd1;
    end

    // Outputs follow the accumulator only in LIVE. The gate uses the next
    // state, so tdc_valid and the data change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdc_ripple_count <= '0;
            tdc_phase        <= '0;
            tdc_valid        <= 1'b0;
        end else if (en) begin
            if (state_d == TDC_LIVE) begin
                tdc_ripple_count <= acc_q[20:14];
                tdc_phase        <= phase_d;
                tdc_valid        <= 1'b1;
            end else begin
                tdc_ripple_count <= '0;
                tdc_phase        <= '0;
                tdc_valid        <= 1'b0;
            end
        end
    end

endmodule
